// File: rtl/fakeram7_bist_pkg.sv
// Shared types for the fakeram7 dual-port March C- BIST: FSM states,
// march element encoding and the per-element operation table.
package fakeram7_bist_pkg;

  localparam int FAIL_ELEM_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bist_state_t;

  typedef enum logic [FAIL_ELEM_W-1:0] {
    E0 = 3'd0,  // up(w0)
    E1 = 3'd1,  // up(r0,w1)
    E2 = 3'd2,  // up(r1,w0)
    E3 = 3'd3,  // down(r0,w1)
    E4 = 3'd4,  // down(r1,w0)
    E5 = 3'd5   // up(r0)
  } march_elem_t;

  // What one march element does at each address.
  typedef struct packed {
    logic       down;    // walk addresses from top to bottom
    logic       has_rd;  // element starts with a read
    logic       rd_val;  // background expected on that read
    logic       has_wr;  // element performs a write
    logic       wr_val;  // background written
    logic [1:0] ops;     // operations per address (1 or 2)
  } elem_info_t;

  // Only E3 and E4 descend; the order-free elements run ascending.
  function automatic logic elem_dir_down(input march_elem_t e);
    return (e == E3) || (e == E4);
  endfunction

  function automatic elem_info_t elem_info(input march_elem_t e);
    elem_info_t info;
    info      = '0;
    info.down = elem_dir_down(e);
    case (e)
      E0: begin info.has_wr = 1'b1; info.wr_val = 1'b0; info.ops = 2'd1; end
      E1: begin info.has_rd = 1'b1; info.rd_val = 1'b0;
                info.has_wr = 1'b1; info.wr_val = 1'b1; info.ops = 2'd2; end
      E2: begin info.has_rd = 1'b1; info.rd_val = 1'b1;
                info.has_wr = 1'b1; info.wr_val = 1'b0; info.ops = 2'd2; end
      E3: begin info.has_rd = 1'b1; info.rd_val = 1'b0;
                info.has_wr = 1'b1; info.wr_val = 1'b1; info.ops = 2'd2; end
      E4: begin info.has_rd = 1'b1; info.rd_val = 1'b1;
                info.has_wr = 1'b1; info.wr_val = 1'b0; info.ops = 2'd2; end
      E5: begin info.has_rd = 1'b1; info.rd_val = 1'b0; info.ops = 2'd1; end
      default: info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/fakeram7_bist_addrgen.sv
// Up/down address counter for the march walk. Load has priority over
// counting; tc flags the last address in the current direction so the
// controller can change element instead of wrapping.
module fakeram7_bist_addrgen
  import fakeram7_bist_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  en,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  tc
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] addr_reg;

  // Address register: reset to 0, load a start address, or step one word.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
    end else if (load) begin
      addr_reg <= load_val;
    end else if (en) begin
      addr_reg <= down ? (addr_reg - ONE) : (addr_reg + ONE);
    end
  end

  assign addr = addr_reg;
  assign tc   = down ? (addr_reg == '0) : (addr_reg == LAST_ADDR);

endmodule

// File: rtl/fakeram7_dp_bist.sv
// March C- BIST controller for a dual-port fakeram7 macro. Port A is
// tested completely, then port B, one RAM operation per cycle. Read
// data returns one cycle after issue and is checked against a one-deep
// expected-data pipeline; the first miscompare of a run is recorded.
module fakeram7_dp_bist
  import fakeram7_bist_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic                   fail_port,
  output logic [FAIL_ELEM_W-1:0] fail_elem,
  output logic [ADDR_WIDTH-1:0]  ram_addr_A,
  output logic [ADDR_WIDTH-1:0]  ram_addr_B,
  output logic                   ram_we_A,
  output logic                   ram_we_B,
  output logic [BITS-1:0]        ram_wd_A,
  output logic [BITS-1:0]        ram_wd_B,
  output logic [BITS-1:0]        ram_mask_A,
  output logic [BITS-1:0]        ram_mask_B,
  output logic                   ram_ce,
  input  logic [BITS-1:0]        ram_rd_A,
  input  logic [BITS-1:0]        ram_rd_B
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  bist_state_t state_reg;
  logic        pass_reg;   // 0 = port A, 1 = port B
  march_elem_t elem_reg;
  logic        phase_reg;  // within a read-write element: 0 = read, 1 = write

  logic                   done_reg;
  logic                   fail_reg;
  logic [ADDR_WIDTH-1:0]  fail_addr_reg;
  logic                   fail_port_reg;
  logic [FAIL_ELEM_W-1:0] fail_elem_reg;

  logic                  cmp_valid_reg;
  logic [BITS-1:0]       cmp_exp_reg;
  logic [ADDR_WIDTH-1:0] cmp_addr_reg;
  march_elem_t           cmp_elem_reg;
  logic                  cmp_port_reg;

  elem_info_t            cur;
  march_elem_t           nxt_elem;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] load_val;
  logic                  addr_tc;
  logic                  run;
  logic                  start_ok;
  logic                  issue_rd;
  logic                  issue_wr;
  logic                  last_op;
  logic                  step;
  logic                  elem_end;
  logic                  pass_end;
  logic                  miscmp;
  logic [BITS-1:0]       rd_sel;

  assign cur      = elem_info(elem_reg);
  assign run      = (state_reg == S_RUN);
  assign start_ok = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // A read-write element reads in phase 0 and writes the same word in
  // phase 1, so a read and a write never share a cycle.
  assign issue_rd = run && cur.has_rd && !phase_reg;
  assign issue_wr = run && cur.has_wr && !(cur.has_rd && !phase_reg);
  assign last_op  = (cur.ops == 2'd1) || phase_reg;
  assign step     = run && last_op;
  assign elem_end = step && addr_tc;
  assign pass_end = elem_end && (elem_reg == E5);

  assign nxt_elem = (elem_reg == E5) ? E0 : march_elem_t'(elem_reg + 3'd1);
  assign load_val = (!start_ok && elem_dir_down(nxt_elem)) ? LAST_ADDR : '0;

  fakeram7_bist_addrgen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LAST_ADDR  (LAST_ADDR)
  ) u_addrgen (
    .clk      (clk),
    .reset    (reset),
    .load     (start_ok || elem_end),
    .load_val (load_val),
    .en       (step && !addr_tc),
    .down     (cur.down),
    .addr     (cur_addr),
    .tc       (addr_tc)
  );

  // Sequencer: FSM state plus pass / element / phase position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pass_reg  <= 1'b0;
      elem_reg  <= E0;
      phase_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state_reg <= S_RUN;
            pass_reg  <= 1'b0;
            elem_reg  <= E0;
            phase_reg <= 1'b0;
          end
        end
        S_RUN: begin
          phase_reg <= (cur.ops == 2'd2) && !phase_reg;
          if (elem_end) begin
            elem_reg <= nxt_elem;
          end
          // Port A's last read flows straight into port B's first write.
          if (pass_end) begin
            if (pass_reg) begin
              state_reg <= S_DRAIN;
            end else begin
              pass_reg <= 1'b1;
            end
          end
        end
        S_DRAIN: state_reg <= S_DONE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rd_sel = cmp_port_reg ? ram_rd_B : ram_rd_A;
  assign miscmp = cmp_valid_reg && (rd_sel != cmp_exp_reg);

  // Compare pipeline and sticky result flags; only the first miscompare
  // of a run captures its location.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_valid_reg <= 1'b0;
      cmp_exp_reg   <= '0;
      cmp_addr_reg  <= '0;
      cmp_elem_reg  <= E0;
      cmp_port_reg  <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      fail_addr_reg <= '0;
      fail_port_reg <= 1'b0;
      fail_elem_reg <= '0;
    end else begin
      cmp_valid_reg <= issue_rd;
      if (issue_rd) begin
        cmp_exp_reg  <= {BITS{cur.rd_val}};
        cmp_addr_reg <= cur_addr;
        cmp_elem_reg <= elem_reg;
        cmp_port_reg <= pass_reg;
      end
      if (start_ok) begin
        done_reg      <= 1'b0;
        fail_reg      <= 1'b0;
        fail_addr_reg <= '0;
        fail_port_reg <= 1'b0;
        fail_elem_reg <= '0;
      end else begin
        if (miscmp && !fail_reg) begin
          fail_reg      <= 1'b1;
          fail_addr_reg <= cmp_addr_reg;
          fail_port_reg <= cmp_port_reg;
          fail_elem_reg <= cmp_elem_reg;
        end
        if (state_reg == S_DRAIN) begin
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done      = done_reg;
  assign fail      = fail_reg;
  assign fail_addr = fail_addr_reg;
  assign fail_port = fail_port_reg;
  assign fail_elem = fail_elem_reg;
  assign ram_ce    = busy;

  // The port not under test is held fully quiet.
  assign ram_addr_A = (run && !pass_reg) ? cur_addr : '0;
  assign ram_addr_B = (run &&  pass_reg) ? cur_addr : '0;
  assign ram_we_A   = issue_wr && !pass_reg;
  assign ram_we_B   = issue_wr &&  pass_reg;
  assign ram_wd_A   = ram_we_A ? {BITS{cur.wr_val}} : '0;
  assign ram_wd_B   = ram_we_B ? {BITS{cur.wr_val}} : '0;
  assign ram_mask_A = ram_we_A ? '1 : '0;
  assign ram_mask_B = ram_we_B ? '1 : '0;

endmodule

// File: tb/tb_fakeram7_dp_bist.sv
// Bench for fakeram7_dp_bist: a 512x32 dual-port RAM model with an
// optional stuck-at bit on one port's read path, directed and random
// fault scenarios, and a March C- reference model of the first failure.
module tb_fakeram7_dp_bist;

  localparam int BITS  = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            busy, done, fail, fail_port, ram_ce;
  logic [AW-1:0]   fail_addr, ram_addr_A, ram_addr_B;
  logic [2:0]      fail_elem;
  logic            ram_we_A, ram_we_B;
  logic [BITS-1:0] ram_wd_A, ram_wd_B, ram_mask_A, ram_mask_B;
  logic [BITS-1:0] rd_A_q, rd_B_q;

  int vectors;
  int miscompares;

  // RAM model state and fault configuration
  logic [BITS-1:0] mem [DEPTH];
  int              wr_count = 0;
  int              bus_bad  = 0;
  bit              scramble;
  bit              flt_en;
  bit              flt_port;
  logic [AW-1:0]   flt_addr;
  int              flt_bit;
  bit              flt_val;

  always #5 clk = ~clk;

  fakeram7_dp_bist dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_port  (fail_port),
    .fail_elem  (fail_elem),
    .ram_addr_A (ram_addr_A),
    .ram_addr_B (ram_addr_B),
    .ram_we_A   (ram_we_A),
    .ram_we_B   (ram_we_B),
    .ram_wd_A   (ram_wd_A),
    .ram_wd_B   (ram_wd_B),
    .ram_mask_A (ram_mask_A),
    .ram_mask_B (ram_mask_B),
    .ram_ce     (ram_ce),
    .ram_rd_A   (rd_A_q),
    .ram_rd_B   (rd_B_q)
  );

  function automatic logic [BITS-1:0] fault_rd(input bit p, input logic [AW-1:0] a,
                                               input logic [BITS-1:0] d);
    logic [BITS-1:0] r;
    r = d;
    if (flt_en && (p == flt_port) && (a == flt_addr)) r[flt_bit] = flt_val;
    return r;
  endfunction

  // Dual-port RAM with registered read data and masked writes.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
    end else if (ram_ce) begin
      if (ram_we_A) mem[ram_addr_A] <= (mem[ram_addr_A] & ~ram_mask_A) | (ram_wd_A & ram_mask_A);
      if (ram_we_B) mem[ram_addr_B] <= (mem[ram_addr_B] & ~ram_mask_B) | (ram_wd_B & ram_mask_B);
      wr_count <= wr_count + int'(ram_we_A) + int'(ram_we_B);
      if ((ram_we_A && ram_mask_A != '1) || (ram_we_B && ram_mask_B != '1) ||
          (ram_we_A && (ram_we_B || ram_mask_B != '0 || ram_wd_B != '0 || ram_addr_B != '0)) ||
          (ram_we_B && (ram_we_A || ram_mask_A != '0 || ram_wd_A != '0 || ram_addr_A != '0)))
        bus_bad <= bus_bad + 1;
      rd_A_q <= fault_rd(1'b0, ram_addr_A, mem[ram_addr_A]);
      rd_B_q <= fault_rd(1'b1, ram_addr_B, mem[ram_addr_B]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walk March C- as written: for each port, each reading element, each
  // address in that element's order; the first read whose stuck bit
  // disagrees with the element's background is the first failure.
  task automatic model_first(output logic f, output logic [AW-1:0] fa,
                             output logic fp, output logic [2:0] fe);
    bit rd_tab [6] = '{0, 1, 1, 1, 1, 1};
    bit rv_tab [6] = '{0, 0, 1, 0, 1, 0};
    bit dn_tab [6] = '{0, 0, 0, 1, 1, 0};
    int a;
    f = 0; fa = '0; fp = 0; fe = '0;
    for (int p = 0; p < 2; p++)
      for (int e = 0; e < 6; e++)
        if (rd_tab[e])
          for (int k = 0; k < DEPTH; k++) begin
            a = dn_tab[e] ? (DEPTH - 1 - k) : k;
            if (!f && flt_en && (p == int'(flt_port)) && (a == int'(flt_addr)) &&
                (flt_val != rv_tab[e])) begin
              f = 1; fa = AW'(a); fp = p[0]; fe = e[2:0];
            end
          end
  endtask

  // One run: optional start re-pulse and optional abort by reset.
  task automatic run_march(input string name, input int restart_at, input int abort_at);
    int ops_tab [6] = '{1, 2, 2, 2, 2, 1};
    int busy_n, ce_bad, w0, b0, c, exp_busy;
    logic [BITS-1:0] acc;
    logic ef, ep;
    logic [AW-1:0] ea;
    logic [2:0] ee;
    busy_n = 0; ce_bad = 0; exp_busy = 1;
    for (int e = 0; e < 6; e++) exp_busy += 2 * DEPTH * ops_tab[e];
    scramble = 1; @(negedge clk); scramble = 0;
    w0 = wr_count; b0 = bus_bad;
    start = 1; @(negedge clk); start = 0;
    check({name, " fail cleared on start"}, fail, 0);
    check({name, " done cleared on start"}, done, 0);
    for (c = 0; c < 12000; c++) begin
      if (busy === 1'b1) busy_n++;
      if (ram_ce !== busy) ce_bad++;
      if (busy === 1'b0 && done === 1'b1) break;
      if (c == abort_at) begin
        reset = 1; @(negedge clk); reset = 0;
        check({name, " busy after abort"}, busy, 0);
        check({name, " ram_ce after abort"}, ram_ce, 0);
        check({name, " done after abort"}, done, 0);
        $display("run %s: aborted at cycle %0d", name, c);
        return;
      end
      start = (c == restart_at);
      @(negedge clk);
    end
    start = 0;
    model_first(ef, ea, ep, ee);
    check({name, " run terminated"}, c < 12000, 1);
    check({name, " busy cycles"}, busy_n, exp_busy);
    check({name, " ram_ce follows busy"}, ce_bad, 0);
    check({name, " write count"}, wr_count - w0, 2 * DEPTH * 5);
    check({name, " bus protocol"}, bus_bad - b0, 0);
    check({name, " done"}, done, 1);
    check({name, " fail"}, fail, ef);
    check({name, " fail_addr"}, fail_addr, ea);
    check({name, " fail_port"}, fail_port, ep);
    check({name, " fail_elem"}, fail_elem, ee);
    acc = '0;
    for (int i = 0; i < DEPTH; i++) acc |= mem[i];
    check({name, " memory background"}, acc, 0);
    $display("run %s: busy=%0d fail=%0b addr=0x%0h port=%0b elem=%0d (model %0b 0x%0h %0b %0d)",
             name, busy_n, fail, fail_addr, fail_port, fail_elem, ef, ea, ep, ee);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1; start = 0; scramble = 0;
    flt_en = 0; flt_port = 0; flt_addr = '0; flt_bit = 0; flt_val = 0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset fail", fail, 0);
    check("reset fail_addr", fail_addr, 0);
    check("reset fail_port", fail_port, 0);
    check("reset fail_elem", fail_elem, 0);
    check("reset ram_ce", ram_ce, 0);
    check("reset ram_we", {ram_we_A, ram_we_B}, 0);
    check("reset ram_addr", {ram_addr_A, ram_addr_B}, 0);
    check("reset ram_wd/mask", |{ram_wd_A, ram_wd_B, ram_mask_A, ram_mask_B}, 0);
    reset = 0;
    @(negedge clk);

    run_march("clean", -1, -1);

    flt_en = 1; flt_port = 0; flt_addr = 9'h1A3; flt_bit = 5; flt_val = 1;
    run_march("A_1A3_b5_sa1", -1, -1);

    flt_en = 1; flt_port = 1; flt_addr = 9'h000; flt_bit = 0; flt_val = 0;
    run_march("B_000_b0_sa0", -1, -1);

    flt_en = 0;
    run_march("abort", -1, 3000);
    run_march("clean_after_abort_restart100", 100, -1);

    flt_en   = 1;
    flt_port = 1'($urandom_range(0, 1));
    flt_addr = AW'($urandom_range(0, DEPTH - 1));
    flt_bit  = $urandom_range(0, BITS - 1);
    flt_val  = 1'($urandom_range(0, 1));
    run_march("random_fault", -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fakeram7_dp_bist.md
FAKERAM7_DP_BIST -- requirements
Module: fakeram7_dp_bist

Interface
REQ-001 SHALL have parameter BITS, default 32, data word width.
REQ-002 SHALL have parameter WORD_DEPTH, default 512, words under test.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, address width; WORD_DEPTH = 2**ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a test run.
REQ-007 SHALL have port busy  output  1  test run in progress.
REQ-008 SHALL have port done  output  1  run complete; held until next accepted start or reset.
REQ-009 SHALL have port fail  output  1  sticky miscompare flag for the current run.
REQ-010 SHALL have port fail_addr  output  ADDR_WIDTH  address of the first miscompare.
REQ-011 SHALL have port fail_port  output  1  port of the first miscompare: 0=A, 1=B.
REQ-012 SHALL have port fail_elem  output  3  march element index (0..5) of the first miscompare.
REQ-013 SHALL have ports ram_addr_A/ram_addr_B  output  ADDR_WIDTH  RAM addresses.
REQ-014 SHALL have ports ram_we_A/ram_we_B  output  1  RAM write enables.
REQ-015 SHALL have ports ram_wd_A/ram_wd_B and ram_mask_A/ram_mask_B  output  BITS  write data and bit masks.
REQ-016 SHALL have port ram_ce  output  1  RAM chip enable.
REQ-017 SHALL have ports ram_rd_A/ram_rd_B  input  BITS  RAM read data, registered in the RAM, valid the cycle after issue.

Function
REQ-018 SHALL run March C- per port: E0 up-or-down(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up-or-down(r0). E0 and E5 run ascending.
REQ-019 SHALL use background "0" = all-zeros and "1" = all-ones (BITS wide); ram_mask of the active port = all-ones on writes.
REQ-020 SHALL test port A fully (pass 0), then port B (pass 1); the idle port holds we=0, addr=0, wd=0, mask=0.
REQ-021 SHALL issue exactly one operation per cycle: read-write elements take 2 cycles per address (read, then write to the same address); single-op elements take 1 cycle per address.
REQ-022 SHALL compare ram_rd of the active port against the expected value in the cycle after each read issue, using a one-stage pipeline register holding expected data, address, element and a valid flag.
REQ-023 SHALL never issue a read and a write to the same address in the same cycle.
REQ-024 SHALL use FSM states IDLE, RUN, DRAIN, DONE: IDLE/DONE --start--> RUN; RUN --last issue of pass 1--> DRAIN; DRAIN --1 cycle--> DONE.
REQ-025 SHALL, between passes, move straight from the last E5 read of port A to the first E0 write of port B, with no idle cycle; the pending port-A compare still completes.
REQ-026 SHALL assert busy in RUN and DRAIN only; per pass 5120 issue cycles at default size; busy high exactly 10241 cycles per run.
REQ-027 SHALL drive ram_ce high only while busy.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL, when start is accepted, clear fail, fail_addr, fail_port, fail_elem and done.
REQ-030 SHALL latch fail_addr, fail_port and fail_elem only on the first miscompare of a run; later miscompares set nothing new.
REQ-031 SHALL handle address wrap: ascending ends at WORD_DEPTH-1, descending ends at 0; the counter never wraps silently into the next element.

Reset
REQ-032 SHALL, on reset, force state IDLE and drive busy=0, done=0, fail=0, fail_addr=0, fail_port=0, fail_elem=0, ram_ce=0, all RAM outputs 0, and compare-valid 0.
REQ-033 SHALL treat reset during RUN/DRAIN as an abort: IDLE on the next cycle, no done, no pending compare evaluated.

Structure
REQ-034 SHALL place in package fakeram7_bist_pkg: the FSM state enum, the march element enum/constants (per-element direction, read value, write value, op count), and the fail_elem width.
REQ-035 SHALL contain one sub-module, fakeram7_bist_addrgen: an up/down address counter with load and terminal-count outputs.

Verification
REQ-036 Bench SHALL cover: clean 512x32 dual-port RAM model, start pulse -> busy high 10241 cycles, then done=1, fail=0.
REQ-037 Bench SHALL cover: port-A read of address 0x1A3 with bit 5 stuck at 1 -> fail=1, fail_addr=0x1A3, fail_port=0, fail_elem=1.
REQ-038 Bench SHALL cover: port-B read of address 0x000 with bit 0 stuck at 0 -> fail=1, fail_addr=0x000, fail_port=1, fail_elem=2.
REQ-039 Bench SHALL cover: start re-pulsed at cycle 100 of a run -> ignored; run length unchanged at 10241 cycles.
REQ-040 Bench SHALL cover: reset asserted at cycle 3000 -> next cycle busy=0, ram_ce=0, done=0; a following start gives a full clean run.
REQ-041 Bench SHALL cover: a run with a fault, then a clean run -> fail cleared on start, second run ends with done=1, fail=0.
